// File: rtl/wb_spi_fifo_pkg.sv
// Shared constants for the buffered Wishbone SPI master: register map,
// STATUS/CTRL bit positions and the shift-engine state type.
package wb_spi_fifo_pkg;

  // Word addresses
  localparam logic [1:0] AdrData   = 2'd0;
  localparam logic [1:0] AdrStatus = 2'd1;
  localparam logic [1:0] AdrCtrl   = 2'd2;
  localparam logic [1:0] AdrRsvd   = 2'd3;

  // Byte lane used for DATA reads/writes
  localparam int unsigned ByteLsb = 24;

  // STATUS bit indices
  localparam int unsigned StatBusy    = 24;
  localparam int unsigned StatTxFull  = 25;
  localparam int unsigned StatTxEmpty = 26;
  localparam int unsigned StatRxFull  = 27;
  localparam int unsigned StatRxEmpty = 28;
  localparam int unsigned StatRxOvf   = 29;
  localparam int unsigned StatTxOvf   = 30;

  // CTRL field positions
  localparam int unsigned CtrlDivLsb = 24;
  localparam int unsigned CtrlCpol   = 23;
  localparam int unsigned CtrlCpha   = 22;

  localparam logic [7:0] DivReset = 8'h07;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } eng_state_e;

endpackage

// File: rtl/wb_spi_fifo_buf.sv
// Synchronous byte FIFO. Pointers carry one extra wrap bit so full/empty
// fall out of a straight compare. A pop in the same cycle as a push on a
// full FIFO frees the slot first, so the push is accepted.
module wb_spi_fifo_buf #(
  parameter int unsigned Depth = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [7:0]  mem_q [Depth];
  logic [Aw:0] wr_q, wr_d;
  logic [Aw:0] rd_q, rd_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[Aw] != rd_q[Aw]) && (wr_q[Aw-1:0] == rd_q[Aw-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q[Aw-1:0]];

  // Pointer advance
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + {{Aw{1'b0}}, 1'b1};
    if (do_pop)  rd_d = rd_q + {{Aw{1'b0}}, 1'b1};
  end

  // Pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage, no reset needed: contents are only visible once written
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[Aw-1:0]] <= data_i;
  end

endmodule

// File: rtl/wb_spi_fifo.sv
// Buffered multi-select SPI master behind a 32-bit Wishbone slave port.
// CPU-queued bytes stream out back-to-back; received bytes collect in RX.
module wb_spi_fifo
  import wb_spi_fifo_pkg::*;
#(
  parameter int unsigned NCS        = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           cyc_i,
  input  logic           stb_i,
  input  logic [1:0]     adr_i,
  input  logic           we_i,
  input  logic [31:0]    dat_i,
  input  logic [3:0]     sel_i,
  output logic           ack_o,
  output logic [31:0]    dat_o,
  output logic           sck,
  output logic [NCS-1:0] ss,
  input  logic           miso,
  output logic           mosi
);

  // Bus handshake and decode
  logic ack_q, ack_d;
  logic wr_acc, rd_acc, status_wr, ctrl_wr;
  logic tx_push, rx_pop;

  // Control/status registers
  logic [7:0]     div_q, div_d;
  logic           cpol_q, cpol_d, cpha_q, cpha_d;
  logic [NCS-1:0] ss_q, ss_d;
  logic           tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;

  // FIFO interfaces
  logic       tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_full, rx_empty;
  logic [7:0] rx_head;

  // Shift engine
  eng_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] half_q, half_d;
  logic [7:0] sr_q, sr_d;
  logic       bit_q, bit_d;
  logic [7:0] div_l_q, div_l_d;
  logic       cpol_l_q, cpol_l_d, cpha_l_q, cpha_l_d;

  logic        busy;
  logic [31:0] status_rd, ctrl_rd;
  logic        unused_bits;

  // Byte selects and the unmapped data bits have no function
  assign unused_bits = ^{sel_i, dat_i};

  assign ack_d     = cyc_i && stb_i && !ack_q;
  assign ack_o     = ack_q;
  assign wr_acc    = ack_q && we_i;
  assign rd_acc    = ack_q && !we_i;
  assign tx_push   = wr_acc && (adr_i == AdrData);
  assign rx_pop    = rd_acc && (adr_i == AdrData);
  assign status_wr = wr_acc && (adr_i == AdrStatus);
  assign ctrl_wr   = wr_acc && (adr_i == AdrCtrl);

  assign busy = (state_q != StIdle) || !tx_empty;
  assign ss   = ss_q;
  assign mosi = (state_q == StShift) && sr_q[7];

  wb_spi_fifo_buf #(
    .Depth(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (tx_push),
    .pop_i  (tx_pop),
    .data_i (dat_i[ByteLsb +: 8]),
    .full_o (tx_full),
    .empty_o(tx_empty),
    .head_o (tx_head)
  );

  wb_spi_fifo_buf #(
    .Depth(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (rx_push),
    .pop_i  (rx_pop),
    .data_i (sr_q),
    .full_o (rx_full),
    .empty_o(rx_empty),
    .head_o (rx_head)
  );

  // CTRL register updates
  always_comb begin
    div_d  = div_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    ss_d   = ss_q;
    if (ctrl_wr) begin
      div_d  = dat_i[CtrlDivLsb +: 8];
      cpol_d = dat_i[CtrlCpol];
      cpha_d = dat_i[CtrlCpha];
      ss_d   = dat_i[NCS-1:0];
    end
  end

  // Sticky overflow flags; a new overflow wins over a same-cycle clear
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    if (status_wr && dat_i[StatTxOvf]) tx_ovf_d = 1'b0;
    if (status_wr && dat_i[StatRxOvf]) rx_ovf_d = 1'b0;
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_push && rx_full && !rx_pop) rx_ovf_d = 1'b1;
  end

  // Engine next state: sample miso at the end of even half-periods and
  // shift at the end of odd ones; this is the same for both CPHA values,
  // only the sck phase differs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    sr_d     = sr_q;
    bit_d    = bit_q;
    div_l_d  = div_l_q;
    cpol_l_d = cpol_l_q;
    cpha_l_d = cpha_l_q;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        rx_push = (state_q == StDone);
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          state_d  = StShift;
          sr_d     = tx_head;
          div_l_d  = div_q;
          cpol_l_d = cpol_q;
          cpha_l_d = cpha_q;
          cnt_d    = 8'd0;
          half_d   = 4'd0;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (cnt_q == div_l_q) begin
          cnt_d  = 8'd0;
          half_d = half_q + 4'd1;
          if (!half_q[0]) bit_d = miso;
          else            sr_d  = {sr_q[6:0], bit_q};
          if (half_q == 4'd15) state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // sck: idles at the live CTRL polarity, at the latched one around a byte
  always_comb begin
    unique case (state_q)
      StShift: sck = cpol_l_q ^ cpha_l_q ^ half_q[0];
      StDone:  sck = cpol_l_q;
      default: sck = cpol_q;
    endcase
  end

  // Read data mux
  always_comb begin
    status_rd              = '0;
    status_rd[StatBusy]    = busy;
    status_rd[StatTxFull]  = tx_full;
    status_rd[StatTxEmpty] = tx_empty;
    status_rd[StatRxFull]  = rx_full;
    status_rd[StatRxEmpty] = rx_empty;
    status_rd[StatRxOvf]   = rx_ovf_q;
    status_rd[StatTxOvf]   = tx_ovf_q;
    ctrl_rd                      = '0;
    ctrl_rd[CtrlDivLsb +: 8]     = div_q;
    ctrl_rd[CtrlCpol]            = cpol_q;
    ctrl_rd[CtrlCpha]            = cpha_q;
    ctrl_rd[NCS-1:0]             = ss_q;
    unique case (adr_i)
      AdrData:   dat_o = rx_empty ? 32'h0 : {rx_head, 24'h0};
      AdrStatus: dat_o = status_rd;
      AdrCtrl:   dat_o = ctrl_rd;
      default:   dat_o = 32'h0;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q    <= 1'b0;
      div_q    <= DivReset;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      ss_q     <= '1;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      half_q   <= 4'd0;
      sr_q     <= 8'd0;
      bit_q    <= 1'b0;
      div_l_q  <= 8'd0;
      cpol_l_q <= 1'b0;
      cpha_l_q <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      div_q    <= div_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      ss_q     <= ss_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      div_l_q  <= div_l_d;
      cpol_l_q <= cpol_l_d;
      cpha_l_q <= cpha_l_d;
    end
  end

endmodule
